// File: rtl/m_dram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// m_dram_arbiter: round-robin N-port arbiter onto one DRAM port, with lock and timeout
// Revision 1.0
// -----------------------------------------------------------------------------
module m_dram_arbiter #(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO   = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NPORT-1:0]    req_valid,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*DW-1:0] req_wdata,
  input  logic [NPORT-1:0]    req_we,
  input  logic [NPORT*3-1:0]  req_ctrl,
  input  logic [NPORT-1:0]    req_lock,
  output logic [NPORT-1:0]    req_grant,
  output logic [NPORT-1:0]    rsp_valid,
  output logic                rsp_err,
  output logic [DW-1:0]       rsp_data,
  output logic [AW-1:0]       w_dram_addr,
  output logic [DW-1:0]       w_dram_wdata,
  output logic                w_dram_we_t,
  output logic [2:0]          w_dram_ctrl,
  output logic                w_dram_le,
  input  logic                w_dram_busy,
  input  logic [DW-1:0]       w_dram_odata
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              lock_vld_q, lock_vld_d;
  logic [PW-1:0]     lock_own_q, lock_own_d;
  logic [PW-1:0]     own_q, own_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              lkbit_q, lkbit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              le_q, le_d;
  logic [NPORT-1:0]  rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;

  logic              w_win_vld;
  logic [PW-1:0]     w_win_idx;
  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_idx;
  logic [NPORT-1:0]  w_win_oh;
  logic [NPORT-1:0]  w_own_oh;

  // Upward scan from rr_q, wrapping at NPORT; a held lock masks all other ports.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_sum = {1'b0, rr_q} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NPORT)) begin
        w_sum = w_sum - (PW+1)'(NPORT);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_win_vld && req_valid[w_idx] && (!lock_vld_q || (lock_own_q == w_idx))) begin
        w_win_vld = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    w_own_oh = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_win_oh[i] = (w_win_idx == PW'(i));
      w_own_oh[i] = (own_q == PW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    lock_vld_d  = lock_vld_q;
    lock_own_d  = lock_own_q;
    own_d       = own_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    ctrl_d      = ctrl_q;
    lkbit_d     = lkbit_q;
    cnt_d       = cnt_q;
    le_d        = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (w_win_vld) begin
          state_d = S_ISSUE;
          own_d   = w_win_idx;
          addr_d  = req_addr[int'(w_win_idx)*AW +: AW];
          wdata_d = req_wdata[int'(w_win_idx)*DW +: DW];
          we_d    = req_we[w_win_idx];
          ctrl_d  = req_ctrl[int'(w_win_idx)*3 +: 3];
          lkbit_d = req_lock[w_win_idx];
          le_d    = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // cnt_q == 0 marks the first WAIT cycle, where busy has not risen yet.
        if ((cnt_q != '0) && !w_dram_busy) begin
          state_d     = S_RESP;
          rsp_valid_d = w_own_oh;
          rsp_data_d  = w_dram_odata;
        end else if ((TMO > 0) && (cnt_q == CW'(TMO - 1))) begin
          state_d     = S_RESP;
          rsp_valid_d = w_own_oh;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        rr_d       = (own_q == PW'(NPORT - 1)) ? '0 : own_q + 1'b1;
        lock_vld_d = lkbit_q && !rsp_err_q;
        lock_own_d = own_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      lock_vld_q  <= 1'b0;
      lock_own_q  <= '0;
      own_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ctrl_q      <= '0;
      lkbit_q     <= 1'b0;
      cnt_q       <= '0;
      le_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_vld_q  <= lock_vld_d;
      lock_own_q  <= lock_own_d;
      own_q       <= own_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      ctrl_q      <= ctrl_d;
      lkbit_q     <= lkbit_d;
      cnt_q       <= cnt_d;
      le_q        <= le_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_grant    = (state_q == S_IDLE && w_win_vld && !RST) ? w_win_oh : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_data     = rsp_data_q;
  assign w_dram_addr  = addr_q;
  assign w_dram_wdata = wdata_q;
  assign w_dram_we_t  = we_q;
  assign w_dram_ctrl  = ctrl_q;
  assign w_dram_le    = le_q;

endmodule
`default_nettype wire
